trigger_timestamp: RTL and testbench

//  Downstream consumer of the trigger block: detects rising edges of trigger_out, stamps each with a

---
 rtl/trigger_ts_pkg.sv | 21 ++
 rtl/trigger_timestamp_if.sv | 22 ++
 rtl/trigger_ts_fifo.sv | 64 ++++++
 rtl/trigger_timestamp.sv | 146 ++++++++++++++
 tb/tb_trigger_timestamp.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_ts_pkg.sv
// =============================================================================
// trigger_ts_pkg : shared FSM state type and default sizing for trigger_timestamp
// Rev 1.0
// =============================================================================
`default_nettype none

package trigger_ts_pkg;

  localparam int DEF_TS_WIDTH   = 32;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_DROP_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/trigger_timestamp_if.sv
// =============================================================================
// trigger_timestamp_if : valid/ready readout channel for queued timestamps
// Rev 1.0
// =============================================================================
`default_nettype none

interface trigger_timestamp_if
  import trigger_ts_pkg::*;
#(
  parameter int TS_WIDTH = DEF_TS_WIDTH
);

  logic                rd_valid;
  logic                rd_ready;
  logic [TS_WIDTH-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

`default_nettype wire

// File: rtl/trigger_ts_fifo.sv
// =============================================================================
// trigger_ts_fifo : synchronous FIFO with occupancy count and zeroed empty output
// Rev 1.0
// =============================================================================
`default_nettype none

module trigger_ts_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst_sync,
  input  wire logic                     clear,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [WIDTH-1:0]         din,
  output logic      [WIDTH-1:0]         dout,
  output logic      [$clog2(DEPTH):0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/trigger_timestamp.sv
// =============================================================================
// trigger_timestamp : stamps rising trigger edges with a prescaled counter into a FIFO
// Optional feature macro: TRIG_TS_HOLDOFF_EN (adds cfg_holdoff edge holdoff). Rev 1.0
// =============================================================================
`default_nettype none

module trigger_timestamp
  import trigger_ts_pkg::*;
#(
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DROP_WIDTH = DEF_DROP_WIDTH
) (
  input  wire logic                   clk,
  input  wire logic                   rst_sync,
  input  wire logic                   trigger_in,
  input  wire logic                   cfg_enable,
  input  wire logic                   cfg_single_shot,
  input  wire logic                   cfg_arm,
  input  wire logic [3:0]             cfg_stage1_count,
`ifdef TRIG_TS_HOLDOFF_EN
  input  wire logic [7:0]             cfg_holdoff,
`endif
  input  wire logic                   ts_clear,
  trigger_timestamp_if.master         rd,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        armed,
  output logic                        overflow,
  output logic [DROP_WIDTH-1:0]       drop_count
);

  state_t              state;
  state_t              state_nxt;
  logic                trig_q;
  logic                trig_edge;
  logic [3:0]          presc;
  logic [3:0]          presc_last;
  logic                tick;
  logic [TS_WIDTH-1:0] ts;
  logic                hold_ok;
  logic                cand;
  logic                pop;
  logic                push;
  logic                drop;
  logic                full;
  logic                fifo_empty;

  assign trig_edge  = trigger_in & ~trig_q;
  assign presc_last = (cfg_stage1_count <= 4'd1) ? 4'd0 : cfg_stage1_count - 4'd1;
  // >= rather than == so a prescale reduced mid-count still wraps promptly.
  assign tick       = (presc >= presc_last);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      trig_q <= 1'b0;
      presc  <= '0;
      ts     <= '0;
    end else begin
      trig_q <= trigger_in;
      if (ts_clear) begin
        presc <= '0;
        ts    <= '0;
      end else if (tick) begin
        presc <= '0;
        ts    <= ts + TS_WIDTH'(1);
      end else begin
        presc <= presc + 4'd1;
      end
    end
  end

`ifdef TRIG_TS_HOLDOFF_EN
  logic [7:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (rst_sync || ts_clear || !cfg_enable) begin
      hold_cnt <= '0;
    end else if (push) begin
      hold_cnt <= cfg_holdoff;
    end else if (tick && hold_cnt != 8'd0) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  assign hold_ok = (hold_cnt == 8'd0);
`else
  assign hold_ok = 1'b1;
`endif

  // An edge coinciding with ts_clear is discarded rather than stamped.
  assign cand = trig_edge & (state == ARMED) & ~ts_clear & hold_ok;
  assign pop  = rd.rd_valid & rd.rd_ready;
  assign push = cand & (~full | pop);
  assign drop = cand & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst_sync || ts_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!cfg_enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (cfg_arm) state_nxt = ARMED;
        ARMED:   if (push && cfg_single_shot) state_nxt = DONE;
        DONE:    if (cfg_arm) state_nxt = ARMED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign armed       = (state == ARMED);
  assign rd.rd_valid = ~fifo_empty;

  trigger_ts_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_sync (rst_sync),
    .clear    (ts_clear),
    .push     (push),
    .pop      (pop),
    .din      (ts),
    .dout     (rd.rd_data),
    .level    (fifo_level),
    .full     (full),
    .empty    (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_trigger_timestamp.sv
// =============================================================================
// tb_trigger_timestamp : directed self-checking bench for trigger_timestamp
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_trigger_timestamp;

  logic        clk = 1'b0;
  logic        rst_sync;
  logic        trigger_in;
  logic        cfg_enable;
  logic        cfg_single_shot;
  logic        cfg_arm;
  logic [3:0]  cfg_stage1_count;
  logic        ts_clear;
  logic [4:0]  fifo_level;
  logic        armed;
  logic        overflow;
  logic [7:0]  drop_count;
`ifdef TRIG_TS_HOLDOFF_EN
  logic [7:0]  cfg_holdoff;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  trigger_timestamp_if #(.TS_WIDTH(32)) rd_if ();

  always #5 clk = ~clk;

  trigger_timestamp #(
    .TS_WIDTH   (32),
    .DEPTH      (16),
    .DROP_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst_sync         (rst_sync),
    .trigger_in       (trigger_in),
    .cfg_enable       (cfg_enable),
    .cfg_single_shot  (cfg_single_shot),
    .cfg_arm          (cfg_arm),
    .cfg_stage1_count (cfg_stage1_count),
`ifdef TRIG_TS_HOLDOFF_EN
    .cfg_holdoff      (cfg_holdoff),
`endif
    .ts_clear         (ts_clear),
    .rd               (rd_if),
    .fifo_level       (fifo_level),
    .armed            (armed),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    cfg_arm = 1'b1;
    step(1);
    cfg_arm = 1'b0;
  endtask

  task automatic do_clear();
    ts_clear = 1'b1;
    step(1);
    ts_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_sync = 1'b1;
    step(3);
    total_cnt++;
    if ({rd_if.rd_valid, fifo_level, armed, overflow, drop_count} !== 16'd0 || rd_if.rd_data !== 32'd0)
      $display("FAIL reset_outputs: valid=%0b data=%0d level=%0d armed=%0b ovf=%0b drops=%0d, want all 0",
               rd_if.rd_valid, rd_if.rd_data, fifo_level, armed, overflow, drop_count);
    else pass_cnt++;
    rst_sync = 1'b0;
    step(1);
    total_cnt++;
    if (armed !== 1'b0 || rd_if.rd_valid !== 1'b0)
      $display("FAIL reset_idle: armed=%0b valid=%0b, want 0 0", armed, rd_if.rd_valid);
    else pass_cnt++;
  endtask

  // Pulses at cycles 10 and 50 after clear with prescale 4 stamp 2 and 12.
  task automatic test_timestamp();
    cfg_enable = 1'b1; cfg_single_shot = 1'b0; cfg_stage1_count = 4'd4;
    do_arm();
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL arm: armed=%0b, want 1", armed); else pass_cnt++;
    do_clear();
    step(9);
    trigger_in = 1'b1;
    total_cnt++;
    if (rd_if.rd_valid !== 1'b0) $display("FAIL latency_pre: valid=%0b, want 0", rd_if.rd_valid); else pass_cnt++;
    step(1);
    total_cnt++;
    if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'd2)
      $display("FAIL stamp_first: valid=%0b data=%0d, want 1 2", rd_if.rd_valid, rd_if.rd_data);
    else pass_cnt++;
    step(7);
    trigger_in = 1'b0;
    step(32);
    trigger_in = 1'b1;
    step(8);
    trigger_in = 1'b0;
    total_cnt++;
    if (fifo_level !== 5'd2 || armed !== 1'b1)
      $display("FAIL multi_shot_level: level=%0d armed=%0b, want 2 1", fifo_level, armed);
    else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    step(1);
    total_cnt++;
    if (rd_if.rd_data !== 32'd12 || fifo_level !== 5'd1)
      $display("FAIL stamp_second: data=%0d level=%0d, want 12 1", rd_if.rd_data, fifo_level);
    else pass_cnt++;
    step(1);
    rd_if.rd_ready = 1'b0;
    total_cnt++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 32'd0)
      $display("FAIL drained: valid=%0b data=%0d, want 0 0", rd_if.rd_valid, rd_if.rd_data);
    else pass_cnt++;
  endtask

  task automatic test_single_shot();
    cfg_single_shot = 1'b1;
    for (int k = 0; k < 3; k++) begin
      trigger_in = 1'b1;
      step(1);
      if (k == 0) begin
        total_cnt++;
        if (armed !== 1'b0) $display("FAIL single_disarm: armed=%0b, want 0", armed); else pass_cnt++;
      end
      step(7);
      trigger_in = 1'b0;
      step(4);
    end
    total_cnt++;
    if (fifo_level !== 5'd1 || drop_count !== 8'd0)
      $display("FAIL single_one_entry: level=%0d drops=%0d, want 1 0", fifo_level, drop_count);
    else pass_cnt++;
    do_arm();
    trigger_in = 1'b1;
    step(8);
    trigger_in = 1'b0;
    step(2);
    total_cnt++;
    if (fifo_level !== 5'd2 || armed !== 1'b0)
      $display("FAIL rearm_capture: level=%0d armed=%0b, want 2 0", fifo_level, armed);
    else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    step(2);
    rd_if.rd_ready = 1'b0;
  endtask

  // 18 one-cycle pulses every 2 clks with prescale 1: pulse k stamps 2k.
  task automatic test_overflow();
    cfg_single_shot = 1'b0; cfg_stage1_count = 4'd1;
    do_arm();
    do_clear();
    for (int k = 0; k < 18; k++) begin
      trigger_in = 1'b1;
      step(1);
      trigger_in = 1'b0;
      step(1);
    end
    total_cnt++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd2)
      $display("FAIL overflow: level=%0d ovf=%0b drops=%0d, want 16 1 2", fifo_level, overflow, drop_count);
    else pass_cnt++;
    total_cnt++;
    if (rd_if.rd_data !== 32'd0) $display("FAIL overflow_head: data=%0d, want 0", rd_if.rd_data); else pass_cnt++;
  endtask

  // Edge at cycle 37 (stamp 36) arrives while full but with a pop in the same cycle.
  task automatic test_full_pop();
    trigger_in = 1'b1;
    rd_if.rd_ready = 1'b1;
    step(1);
    trigger_in = 1'b0;
    rd_if.rd_ready = 1'b0;
    total_cnt++;
    if (fifo_level !== 5'd16 || drop_count !== 8'd2 || rd_if.rd_data !== 32'd2)
      $display("FAIL full_push_pop: level=%0d drops=%0d head=%0d, want 16 2 2", fifo_level, drop_count, rd_if.rd_data);
    else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      automatic logic [31:0] exp_v = (i < 15) ? 32'(2 * (i + 1)) : 32'd36;
      total_cnt++;
      if (rd_if.rd_data !== exp_v) $display("FAIL drain_%0d: data=%0d, want %0d", i, rd_if.rd_data, exp_v);
      else pass_cnt++;
      step(1);
    end
    rd_if.rd_ready = 1'b0;
    total_cnt++;
    if (rd_if.rd_valid !== 1'b0) $display("FAIL drain_empty: valid=%0b, want 0", rd_if.rd_valid); else pass_cnt++;
  endtask

  task automatic test_clear_enable();
    trigger_in = 1'b1;
    step(1);
    trigger_in = 1'b0;
    step(1);
    total_cnt++;
    if (fifo_level !== 5'd1) $display("FAIL clear_setup: level=%0d, want 1", fifo_level); else pass_cnt++;
    trigger_in = 1'b1;
    ts_clear = 1'b1;
    step(1);
    ts_clear = 1'b0;
    trigger_in = 1'b0;
    total_cnt++;
    if (fifo_level !== 5'd0 || rd_if.rd_valid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'd0 || armed !== 1'b1)
      $display("FAIL ts_clear: level=%0d valid=%0b ovf=%0b drops=%0d armed=%0b, want 0 0 0 0 1",
               fifo_level, rd_if.rd_valid, overflow, drop_count, armed);
    else pass_cnt++;
    cfg_enable = 1'b0;
    step(1);
    trigger_in = 1'b1;
    step(2);
    trigger_in = 1'b0;
    total_cnt++;
    if (armed !== 1'b0 || fifo_level !== 5'd0)
      $display("FAIL disable: armed=%0b level=%0d, want 0 0", armed, fifo_level);
    else pass_cnt++;
    cfg_enable = 1'b1;
    do_arm();
    total_cnt++;
    if (armed !== 1'b1) $display("FAIL reenable_arm: armed=%0b, want 1", armed); else pass_cnt++;
  endtask

`ifdef TRIG_TS_HOLDOFF_EN
  // Holdoff 5, prescale 1, edges every 3 clks from cycle 1: stamps 0, 6, 12 kept.
  task automatic test_holdoff();
    cfg_holdoff = 8'd5;
    cfg_stage1_count = 4'd1;
    do_clear();
    for (int k = 0; k < 6; k++) begin
      trigger_in = 1'b1;
      step(1);
      trigger_in = 1'b0;
      step(2);
    end
    total_cnt++;
    if (fifo_level !== 5'd3 || drop_count !== 8'd0)
      $display("FAIL holdoff_level: level=%0d drops=%0d, want 3 0", fifo_level, drop_count);
    else pass_cnt++;
    rd_if.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (rd_if.rd_data !== 32'(6 * i)) $display("FAIL holdoff_stamp_%0d: data=%0d, want %0d", i, rd_if.rd_data, 6 * i);
      else pass_cnt++;
      step(1);
    end
    rd_if.rd_ready = 1'b0;
  endtask
`endif

  initial begin
    rst_sync = 1'b1; trigger_in = 1'b0; cfg_enable = 1'b0; cfg_single_shot = 1'b0;
    cfg_arm = 1'b0; cfg_stage1_count = 4'd0; ts_clear = 1'b0; rd_if.rd_ready = 1'b0;
`ifdef TRIG_TS_HOLDOFF_EN
    cfg_holdoff = 8'd0;
`endif
    step(1);
    test_reset();
    test_timestamp();
    test_single_shot();
    test_overflow();
    test_full_pop();
    test_clear_enable();
`ifdef TRIG_TS_HOLDOFF_EN
    test_holdoff();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
